// File: rtl/cmp_share_ctrl_pkg.sv
// Shared definitions for the shared-comparator controller: condition codes,
// flag bit positions, FSM states and the condition evaluation helper.
package cmp_share_ctrl_pkg;

   localparam logic [2:0] COND_EQ  = 3'b000;
   localparam logic [2:0] COND_NE  = 3'b001;
   localparam logic [2:0] COND_LT  = 3'b100;
   localparam logic [2:0] COND_GE  = 3'b101;
   localparam logic [2:0] COND_LTU = 3'b110;
   localparam logic [2:0] COND_GEU = 3'b111;

   localparam int unsigned FLAG_EQ  = 4;
   localparam int unsigned FLAG_LT  = 3;
   localparam int unsigned FLAG_LTU = 2;
   localparam int unsigned FLAG_GE  = 1;
   localparam int unsigned FLAG_GEU = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_RESP
   } state_t;

   // Returns {illegal, taken}; reserved codes 010/011 never take.
   function automatic logic [1:0] cond_eval(input logic [2:0] cond, input logic [4:0] flag);
      logic [1:0] res;
      res = 2'b00;
      case (cond)
         COND_EQ:  res = {1'b0, flag[FLAG_EQ]};
         COND_NE:  res = {1'b0, ~flag[FLAG_EQ]};
         COND_LT:  res = {1'b0, flag[FLAG_LT]};
         COND_GE:  res = {1'b0, flag[FLAG_GE]};
         COND_LTU: res = {1'b0, flag[FLAG_LTU]};
         COND_GEU: res = {1'b0, flag[FLAG_GEU]};
         default:  res = 2'b10;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/Cmp.sv
// Signed/unsigned magnitude comparator producing {EQ, LT, LTU, GE, GEU}.
module Cmp
   import cmp_share_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 64
) (
   input  logic [DATA_WIDTH-1:0] in_numA,
   input  logic [DATA_WIDTH-1:0] in_numB,
   output logic [4:0]            out_flag
);

   logic lt_s;
   logic lt_u;

   assign lt_s = $signed(in_numA) < $signed(in_numB);
   assign lt_u = in_numA < in_numB;

   always_comb begin
      out_flag           = '0;
      out_flag[FLAG_EQ]  = (in_numA == in_numB);
      out_flag[FLAG_LT]  = lt_s;
      out_flag[FLAG_LTU] = lt_u;
      out_flag[FLAG_GE]  = ~lt_s;
      out_flag[FLAG_GEU] = ~lt_u;
   end

endmodule

// File: rtl/cmp_rr_pick.sv
// Combinational round-robin picker: first valid index at or above ptr, wrapping.
module cmp_rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] in_valid,
   input  logic [PTR_W-1:0]   in_ptr,
   output logic [NUM_REQ-1:0] out_grant,
   output logic [PTR_W-1:0]   out_idx,
   output logic               out_any
);

   always_comb begin
      int unsigned k;
      out_grant = '0;
      out_idx   = '0;
      out_any   = 1'b0;
      k         = 0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         k = (32'(in_ptr) + off) % NUM_REQ;
         if (!out_any && in_valid[k]) begin
            out_any      = 1'b1;
            out_grant[k] = 1'b1;
            out_idx      = PTR_W'(k);
         end
      end
   end

endmodule

// File: rtl/cmp_share_ctrl.sv
// Shares one Cmp between NUM_REQ requesters with round-robin arbitration;
// the result is registered and held until the owning requester accepts it.
module cmp_share_ctrl
   import cmp_share_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned PTR_W      = 2
) (
   input  logic                          in_clk,
   input  logic                          in_rst,
   input  logic [NUM_REQ-1:0]            in_req_valid,
   output logic [NUM_REQ-1:0]            out_req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] in_req_numA,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] in_req_numB,
   input  logic [NUM_REQ*3-1:0]          in_req_cond,
   output logic [NUM_REQ-1:0]            out_rsp_valid,
   input  logic [NUM_REQ-1:0]            in_rsp_ready,
   output logic                          out_rsp_taken,
   output logic [4:0]                    out_rsp_flag,
   output logic                          out_rsp_illegal,
   output logic                          out_busy
);

   state_t                 state, state_n;
   logic [PTR_W-1:0]       ptr;
   logic [PTR_W-1:0]       grant_idx;
   logic [DATA_WIDTH-1:0]  numA_r;
   logic [DATA_WIDTH-1:0]  numB_r;
   logic [2:0]             cond_r;
   logic [4:0]             cmp_flag;
   logic [1:0]             cond_res;
   logic [NUM_REQ-1:0]     pick_grant;
   logic [PTR_W-1:0]       pick_idx;
   logic                   pick_any;
   logic                   rsp_done;

   cmp_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_pick (
      .in_valid  (in_req_valid),
      .in_ptr    (ptr),
      .out_grant (pick_grant),
      .out_idx   (pick_idx),
      .out_any   (pick_any)
   );

   Cmp #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_cmp (
      .in_numA  (numA_r),
      .in_numB  (numB_r),
      .out_flag (cmp_flag)
   );

   assign cond_res = cond_eval(cond_r, cmp_flag);
   assign rsp_done = (state == ST_RESP) && in_rsp_ready[grant_idx];

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: if (pick_any) state_n = ST_EXEC;
         ST_EXEC: state_n = ST_RESP;
         ST_RESP: if (rsp_done) state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         state           <= ST_IDLE;
         ptr             <= '0;
         grant_idx       <= '0;
         numA_r          <= '0;
         numB_r          <= '0;
         cond_r          <= '0;
         out_rsp_taken   <= 1'b0;
         out_rsp_flag    <= '0;
         out_rsp_illegal <= 1'b0;
      end else begin
         state <= state_n;
         if (state == ST_IDLE && pick_any) begin
            grant_idx <= pick_idx;
            numA_r    <= in_req_numA[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
            numB_r    <= in_req_numB[int'(pick_idx)*3*0 + int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
            cond_r    <= in_req_cond[int'(pick_idx)*3 +: 3];
         end
         if (state == ST_EXEC) begin
            out_rsp_flag    <= cmp_flag;
            out_rsp_taken   <= cond_res[0];
            out_rsp_illegal <= cond_res[1];
         end
         if (rsp_done) begin
            ptr <= (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
         end
      end
   end

   // Ready is gated by reset so every output reads zero while reset is held.
   always_comb begin
      out_req_ready = '0;
      out_rsp_valid = '0;
      if (state == ST_IDLE && !in_rst) out_req_ready = pick_grant;
      if (state == ST_RESP) out_rsp_valid[grant_idx] = 1'b1;
   end

   assign out_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_cmp_share_ctrl.sv
// Directed self-checking bench for cmp_share_ctrl (table of single ops plus
// fairness, backpressure and reset-in-flight sequences).
module tb_cmp_share_ctrl;

   localparam int unsigned DW = 64;
   localparam int unsigned NR = 4;

   logic              in_clk = 1'b0;
   logic              in_rst;
   logic [NR-1:0]     in_req_valid;
   logic [NR-1:0]     out_req_ready;
   logic [NR*DW-1:0]  in_req_numA;
   logic [NR*DW-1:0]  in_req_numB;
   logic [NR*3-1:0]   in_req_cond;
   logic [NR-1:0]     out_rsp_valid;
   logic [NR-1:0]     in_rsp_ready;
   logic              out_rsp_taken;
   logic [4:0]        out_rsp_flag;
   logic              out_rsp_illegal;
   logic              out_busy;

   int n_checks = 0;
   int n_fail   = 0;

   cmp_share_ctrl #(
      .DATA_WIDTH (DW),
      .NUM_REQ    (NR),
      .PTR_W      (2)
   ) dut (
      .in_clk          (in_clk),
      .in_rst          (in_rst),
      .in_req_valid    (in_req_valid),
      .out_req_ready   (out_req_ready),
      .in_req_numA     (in_req_numA),
      .in_req_numB     (in_req_numB),
      .in_req_cond     (in_req_cond),
      .out_rsp_valid   (out_rsp_valid),
      .in_rsp_ready    (in_rsp_ready),
      .out_rsp_taken   (out_rsp_taken),
      .out_rsp_flag    (out_rsp_flag),
      .out_rsp_illegal (out_rsp_illegal),
      .out_busy        (out_busy)
   );

   always #5 in_clk = ~in_clk;

   typedef struct {
      int unsigned req;
      logic [63:0] a;
      logic [63:0] b;
      logic [2:0]  cond;
      logic        taken;
      logic [4:0]  flag;
      logic        ill;
   } vec_t;

   vec_t tbl[9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic load(input int unsigned r, input logic [63:0] a, input logic [63:0] b,
                       input logic [2:0] c);
      in_req_numA[r*DW +: DW] = a;
      in_req_numB[r*DW +: DW] = b;
      in_req_cond[r*3 +: 3]   = c;
   endtask

   task automatic run_op(input vec_t v);
      logic [3:0] oh;
      oh = 4'b0001 << v.req;
      @(posedge in_clk); #1;
      load(v.req, v.a, v.b, v.cond);
      in_req_valid = oh;
      @(negedge in_clk);
      check("op_ready", 64'(out_req_ready), 64'(oh));
      check("op_idle_busy", 64'(out_busy), 64'd0);
      @(posedge in_clk); #1;
      in_req_valid = '0;
      @(negedge in_clk);
      check("op_exec_busy", 64'(out_busy), 64'd1);
      check("op_exec_rsp", 64'(out_rsp_valid), 64'd0);
      @(negedge in_clk);
      check("op_rsp_valid", 64'(out_rsp_valid), 64'(oh));
      check("op_taken", 64'(out_rsp_taken), 64'(v.taken));
      check("op_flag", 64'(out_rsp_flag), 64'(v.flag));
      check("op_illegal", 64'(out_rsp_illegal), 64'(v.ill));
      in_rsp_ready = oh;
      @(posedge in_clk); #1;
      in_rsp_ready = '0;
      @(negedge in_clk);
      check("op_done_busy", 64'(out_busy), 64'd0);
   endtask

   initial begin
      in_rst       = 1'b1;
      in_req_valid = '0;
      in_rsp_ready = '0;
      in_req_numA  = '0;
      in_req_numB  = '0;
      in_req_cond  = '0;

      tbl[0] = '{0, 64'd5, 64'd7, 3'b100, 1'b1, 5'b01100, 1'b0};
      tbl[1] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b110, 1'b0, 5'b01001, 1'b0};
      tbl[2] = '{2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b100, 1'b1, 5'b01001, 1'b0};
      tbl[3] = '{3, 64'd3, 64'd3, 3'b010, 1'b0, 5'b10011, 1'b1};
      tbl[4] = '{0, 64'd3, 64'd3, 3'b011, 1'b0, 5'b10011, 1'b1};
      tbl[5] = '{1, 64'd9, 64'd9, 3'b000, 1'b1, 5'b10011, 1'b0};
      tbl[6] = '{2, 64'd9, 64'd8, 3'b001, 1'b1, 5'b00011, 1'b0};
      tbl[7] = '{3, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 3'b111, 1'b1, 5'b01001, 1'b0};
      tbl[8] = '{0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b101, 1'b1, 5'b00110, 1'b0};

      // Reset state
      in_req_valid = 4'b1111;
      #12;
      check("rst_ready", 64'(out_req_ready), 64'd0);
      check("rst_rsp_valid", 64'(out_rsp_valid), 64'd0);
      check("rst_busy", 64'(out_busy), 64'd0);
      check("rst_flag", 64'(out_rsp_flag), 64'd0);
      in_req_valid = '0;
      @(negedge in_clk);
      in_rst = 1'b0;

      // Fairness: all valid, responses always accepted; order 0,1,2,3,0,1
      for (int unsigned i = 0; i < NR; i++) load(i, 64'(i), 64'd2, 3'b100);
      @(posedge in_clk); #1;
      in_req_valid = 4'b1111;
      in_rsp_ready = 4'b1111;
      for (int unsigned k = 0; k < 6; k++) begin
         @(negedge in_clk);
         check("fair_ready", 64'(out_req_ready), 64'(4'b0001 << (k % 4)));
         @(negedge in_clk);
         check("fair_exec_ready", 64'(out_req_ready), 64'd0);
         @(negedge in_clk);
         check("fair_rsp", 64'(out_rsp_valid), 64'(4'b0001 << (k % 4)));
         check("fair_taken", 64'(out_rsp_taken), 64'((k % 4) < 2));
      end
      in_req_valid = '0;
      @(posedge in_clk); #1;
      in_rsp_ready = '0;

      // Single operations from the table
      foreach (tbl[i]) run_op(tbl[i]);

      // Backpressure: req2 GE 9,9 held for 5 cycles, req1 waits
      @(posedge in_clk); #1;
      load(2, 64'd9, 64'd9, 3'b101);
      load(1, 64'd1, 64'd1, 3'b000);
      in_req_valid = 4'b0100;
      @(negedge in_clk);
      check("bp_ready", 64'(out_req_ready), 64'b0100);
      @(posedge in_clk); #1;
      in_req_valid = 4'b0010;
      @(negedge in_clk);
      check("bp_exec_ready", 64'(out_req_ready), 64'd0);
      for (int unsigned c = 0; c < 5; c++) begin
         @(negedge in_clk);
         check("bp_rsp_valid", 64'(out_rsp_valid), 64'b0100);
         check("bp_taken", 64'(out_rsp_taken), 64'd1);
         check("bp_flag", 64'(out_rsp_flag), 64'b10011);
         check("bp_no_ready", 64'(out_req_ready), 64'd0);
         in_rsp_ready = (c == 2) ? 4'b0010 : 4'b0000;
      end
      @(negedge in_clk);
      check("bp_still_held", 64'(out_rsp_valid), 64'b0100);
      in_rsp_ready = 4'b0100;
      @(posedge in_clk); #1;
      in_rsp_ready = '0;
      @(negedge in_clk);
      check("bp_rsp_cleared", 64'(out_rsp_valid), 64'd0);
      check("bp_req1_ready", 64'(out_req_ready), 64'b0010);
      @(posedge in_clk); #1;
      in_req_valid = '0;
      in_rsp_ready = 4'b0010;
      begin
         int unsigned t = 0;
         while (out_rsp_valid != 4'b0010 && t < 20) begin
            @(negedge in_clk);
            t++;
         end
         check("bp_req1_rsp", 64'(out_rsp_valid), 64'b0010);
         check("bp_req1_taken", 64'(out_rsp_taken), 64'd1);
      end
      @(posedge in_clk); #1;
      in_rsp_ready = '0;

      // Reset while in EXEC; ptr was 2, returns to 0
      load(2, 64'd1, 64'd2, 3'b100);
      in_req_valid = 4'b0100;
      @(posedge in_clk); #1;
      in_req_valid = '0;
      @(negedge in_clk);
      check("mid_busy", 64'(out_busy), 64'd1);
      load(3, 64'd0, 64'd0, 3'b000);
      load(0, 64'd5, 64'd7, 3'b100);
      in_req_valid = 4'b1001;
      in_rst = 1'b1;
      #1;
      check("mid_rst_busy", 64'(out_busy), 64'd0);
      check("mid_rst_ready", 64'(out_req_ready), 64'd0);
      check("mid_rst_taken", 64'(out_rsp_taken), 64'd0);
      check("mid_rst_flag", 64'(out_rsp_flag), 64'd0);
      check("mid_rst_rsp", 64'(out_rsp_valid), 64'd0);
      @(negedge in_clk);
      check("mid_rst_held_rsp", 64'(out_rsp_valid), 64'd0);
      in_rst = 1'b0;
      #1;
      check("post_rst_grant", 64'(out_req_ready), 64'b0001);
      @(posedge in_clk); #1;
      in_req_valid = 4'b1000;
      @(negedge in_clk);
      @(negedge in_clk);
      check("post_rst_rsp", 64'(out_rsp_valid), 64'b0001);
      check("post_rst_taken", 64'(out_rsp_taken), 64'd1);
      check("post_rst_flag", 64'(out_rsp_flag), 64'b01100);
      in_rsp_ready = 4'b0001;
      @(posedge in_clk); #1;
      in_rsp_ready = '0;
      @(negedge in_clk);
      check("post_rst_next", 64'(out_req_ready), 64'b1000);
      in_req_valid = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
